regfile_write_port: RTL and testbench

REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

---
 rtl/regfile_write_port.sv | 183 ++++++++++++++++++
 tb/tb_regfile_write_port.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_port.sv
// Register-file write port: power-on sweep that writes rN <= N for r0..r7,
// then an in-order write queue in front of a stallable register-file port.
// Optional read bypass from pending writes: define REGFILE_WRITE_PORT_BYPASS_EN.
module regfile_write_port #(
  parameter int unsigned QDEPTH = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       In_valid,
  output logic       In_ready,
  input  logic [2:0] In_reg_num,
  input  logic [7:0] In_data,
  input  logic       Wr_stall,
  output logic [2:0] Write_reg_num,
  output logic [7:0] Write_data,
  output logic       RegWrite,
  output logic       Init_done,
  input  logic [2:0] Read_reg_num_1,
  input  logic [2:0] Read_reg_num_2,
  input  logic [7:0] Rf_data_1,
  input  logic [7:0] Rf_data_2,
  output logic [7:0] Fwd_data_1,
  output logic [7:0] Fwd_data_2
);

  localparam int unsigned REG_W  = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = $clog2(QDEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [REG_W-1:0]  reg_num;
    logic [DATA_W-1:0] data;
  } wr_entry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [REG_W-1:0] sweep_q, sweep_d;
  logic             init_done_q, init_done_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wr_entry_t        queue_q [QDEPTH];
  logic             push;
  logic             pop;

  // Control state; reset discards queued writes and restarts the sweep
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_INIT;
      sweep_q     <= '0;
      init_done_q <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      init_done_q <= init_done_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Queue payload storage; validity is tracked by the pointers and count
  always_ff @(posedge Clk) begin
    if (push) begin
      queue_q[wr_ptr_q] <= wr_entry_t'({In_reg_num, In_data});
    end
  end

  // Next-state, queue bookkeeping and write-port drive
  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    init_done_d   = init_done_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    push          = 1'b0;
    pop           = 1'b0;
    In_ready      = 1'b0;
    RegWrite      = 1'b0;
    Write_reg_num = '0;
    Write_data    = '0;

    unique case (state_q)
      ST_INIT: begin
        Write_reg_num = sweep_q;
        Write_data    = DATA_W'(sweep_q);
        if (!Wr_stall) begin
          RegWrite = 1'b1;
          if (&sweep_q) begin
            state_d     = ST_RUN;
            init_done_d = 1'b1;
            sweep_d     = '0;
          end else begin
            sweep_d = sweep_q + REG_W'(1);
          end
        end
      end
      ST_RUN: begin
        pop      = (count_q != '0) && !Wr_stall;
        In_ready = (count_q < CNT_W'(QDEPTH)) || pop;
        push     = In_valid && In_ready;
        RegWrite = pop;
        if (count_q != '0) begin
          Write_reg_num = queue_q[rd_ptr_q].reg_num;
          Write_data    = queue_q[rd_ptr_q].data;
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
          wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Held quiet while reset is asserted, independent of the stall input
    if (!Reset) begin
      push          = 1'b0;
      pop           = 1'b0;
      In_ready      = 1'b0;
      RegWrite      = 1'b0;
      Write_reg_num = '0;
      Write_data    = '0;
    end
  end

  assign Init_done = init_done_q;

`ifdef REGFILE_WRITE_PORT_BYPASS_EN
  // Youngest pending write to the read register wins; the sweep entry counts too
  function automatic logic [DATA_W-1:0] bypass_lookup(
    input logic [REG_W-1:0]  rd_addr,
    input logic [DATA_W-1:0] rf_data,
    input logic              in_init,
    input logic [REG_W-1:0]  sweep,
    input logic [PTR_W-1:0]  rd_ptr,
    input logic [CNT_W-1:0]  count,
    input wr_entry_t         entries [QDEPTH]
  );
    logic [DATA_W-1:0] result;
    logic [PTR_W-1:0]  idx;
    result = rf_data;
    if (in_init && (sweep == rd_addr)) begin
      result = DATA_W'(sweep);
    end
    for (int unsigned i = 0; i < QDEPTH; i++) begin
      idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[idx].reg_num == rd_addr)) begin
        result = entries[idx].data;
      end
    end
    return result;
  endfunction

  // Read-port bypass from the sweep entry and the write queue
  always_comb begin
    Fwd_data_1 = bypass_lookup(Read_reg_num_1, Rf_data_1, state_q == ST_INIT,
                               sweep_q, rd_ptr_q, count_q, queue_q);
    Fwd_data_2 = bypass_lookup(Read_reg_num_2, Rf_data_2, state_q == ST_INIT,
                               sweep_q, rd_ptr_q, count_q, queue_q);
  end
`else
  logic unused_rd_addr;

  assign Fwd_data_1     = Rf_data_1;
  assign Fwd_data_2     = Rf_data_2;
  assign unused_rd_addr = ^{Read_reg_num_1, Read_reg_num_2};
`endif

endmodule

// File: tb/tb_regfile_write_port.sv
// Bench for regfile_write_port: directed scenarios plus random traffic,
// every cycle compared against a queue-based reference model.
module tb_regfile_write_port;

  localparam int unsigned QDEPTH = 4;

  logic       Clk;
  logic       Reset;
  logic       In_valid;
  logic       In_ready;
  logic [2:0] In_reg_num;
  logic [7:0] In_data;
  logic       Wr_stall;
  logic [2:0] Write_reg_num;
  logic [7:0] Write_data;
  logic       RegWrite;
  logic       Init_done;
  logic [2:0] Read_reg_num_1;
  logic [2:0] Read_reg_num_2;
  logic [7:0] Rf_data_1;
  logic [7:0] Rf_data_2;
  logic [7:0] Fwd_data_1;
  logic [7:0] Fwd_data_2;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0] r;
    logic [7:0] d;
  } ent_t;

  // Reference model state
  ent_t q[$];
  bit   m_done;
  int   m_sweep;

  regfile_write_port #(.QDEPTH(QDEPTH)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .In_valid      (In_valid),
    .In_ready      (In_ready),
    .In_reg_num    (In_reg_num),
    .In_data       (In_data),
    .Wr_stall      (Wr_stall),
    .Write_reg_num (Write_reg_num),
    .Write_data    (Write_data),
    .RegWrite      (RegWrite),
    .Init_done     (Init_done),
    .Read_reg_num_1(Read_reg_num_1),
    .Read_reg_num_2(Read_reg_num_2),
    .Rf_data_1     (Rf_data_1),
    .Rf_data_2     (Rf_data_2),
    .Fwd_data_1    (Fwd_data_1),
    .Fwd_data_2    (Fwd_data_2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_fwd(input logic [2:0] ra, input logic [7:0] rf);
    logic [7:0] r;
    r = rf;
`ifdef REGFILE_WRITE_PORT_BYPASS_EN
    if (!m_done && (m_sweep == int'(ra))) r = 8'(m_sweep);
    foreach (q[i]) begin
      if (q[i].r == ra) r = q[i].d;
    end
`endif
    return r;
  endfunction

  // One clock cycle: drive at negedge, check, then advance the model at posedge
  task automatic cycle(input logic v, input logic st, input logic [2:0] rn, input logic [7:0] d);
    bit         pop;
    bit         rdy;
    bit         we;
    logic [2:0] en;
    logic [7:0] ed;
    In_valid   = v;
    Wr_stall   = st;
    In_reg_num = rn;
    In_data    = d;
    #1;
    if (!m_done) begin
      we  = !st;
      en  = 3'(m_sweep);
      ed  = 8'(m_sweep);
      rdy = 1'b0;
      pop = 1'b0;
    end else begin
      pop = (q.size() > 0) && !st;
      we  = pop;
      en  = (q.size() > 0) ? q[0].r : 3'd0;
      ed  = (q.size() > 0) ? q[0].d : 8'd0;
      rdy = (q.size() < QDEPTH) || pop;
    end
    chk("RegWrite", 32'(RegWrite), 32'(we));
    chk("Write_reg_num", 32'(Write_reg_num), 32'(en));
    chk("Write_data", 32'(Write_data), 32'(ed));
    chk("In_ready", 32'(In_ready), 32'(rdy));
    chk("Init_done", 32'(Init_done), 32'(m_done));
    chk("Fwd_data_1", 32'(Fwd_data_1), 32'(exp_fwd(Read_reg_num_1, Rf_data_1)));
    chk("Fwd_data_2", 32'(Fwd_data_2), 32'(exp_fwd(Read_reg_num_2, Rf_data_2)));
    @(posedge Clk);
    if (!m_done) begin
      if (!st) begin
        if (m_sweep == 7) m_done = 1'b1;
        else m_sweep++;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (v && rdy) q.push_back({rn, d});
    end
    @(negedge Clk);
  endtask

  task automatic rand_cycle(input int stall_pct);
    Read_reg_num_1 = 3'($urandom);
    Read_reg_num_2 = 3'($urandom);
    Rf_data_1      = 8'($urandom);
    Rf_data_2      = 8'($urandom);
    cycle(1'($urandom), ($urandom_range(0, 99) < stall_pct), 3'($urandom), 8'($urandom));
  endtask

  // Assert reset, check outputs immediately, hold two cycles, release at negedge
  task automatic do_reset(input string tag);
    Reset = 1'b0;
    #1;
    chk({tag, "_RegWrite"}, 32'(RegWrite), 32'd0);
    chk({tag, "_Write_reg_num"}, 32'(Write_reg_num), 32'd0);
    chk({tag, "_Write_data"}, 32'(Write_data), 32'd0);
    chk({tag, "_In_ready"}, 32'(In_ready), 32'd0);
    chk({tag, "_Init_done"}, 32'(Init_done), 32'd0);
    q.delete();
    m_done  = 1'b0;
    m_sweep = 0;
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  initial begin
    Reset          = 1'b1;
    In_valid       = 1'b0;
    In_reg_num     = '0;
    In_data        = '0;
    Wr_stall       = 1'b0;
    Read_reg_num_1 = '0;
    Read_reg_num_2 = '0;
    Rf_data_1      = '0;
    Rf_data_2      = '0;
    m_done         = 1'b0;
    m_sweep        = 0;
    #2;
    do_reset("por");

    // Unstalled sweep r0..r7, then ready
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 3'd0, 8'd0);
    #1;
    chk("init_done_after_sweep", 32'(Init_done), 32'd1);
    cycle(1'b0, 1'b0, 3'd0, 8'd0);

    // Single write through an empty queue
    cycle(1'b1, 1'b0, 3'd3, 8'hA5);
    #1;
    chk("single_we", 32'(RegWrite), 32'd1);
    chk("single_reg", 32'(Write_reg_num), 32'd3);
    chk("single_data", 32'(Write_data), 32'hA5);
    cycle(1'b0, 1'b0, 3'd0, 8'd0);
    cycle(1'b0, 1'b0, 3'd0, 8'd0);

    // Fill under stall, then push+pop at full, then drain in order
    for (int i = 0; i < QDEPTH; i++) cycle(1'b1, 1'b1, 3'(i + 1), 8'(8'h10 + i));
    #1;
    chk("full_not_ready", 32'(In_ready), 32'd0);
    cycle(1'b1, 1'b1, 3'd7, 8'h77);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 3'(i), 8'(8'h40 + i));
    for (int i = 0; i < QDEPTH + 2; i++) cycle(1'b0, 1'b0, 3'd0, 8'd0);

    // Two pending writes to r5: bypass must return the younger one
    Read_reg_num_1 = 3'd5;
    Rf_data_1      = 8'h05;
    cycle(1'b1, 1'b1, 3'd5, 8'h11);
    cycle(1'b1, 1'b1, 3'd5, 8'h22);
    #1;
`ifdef REGFILE_WRITE_PORT_BYPASS_EN
    chk("fwd_youngest", 32'(Fwd_data_1), 32'h22);
`else
    chk("fwd_passthru", 32'(Fwd_data_1), 32'h05);
`endif
    cycle(1'b0, 1'b1, 3'd0, 8'd0);
    for (int i = 0; i < QDEPTH + 1; i++) cycle(1'b0, 1'b0, 3'd0, 8'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) rand_cycle(40);

    // Reset with three queued entries; they must never be written
    for (int i = 0; i < QDEPTH + 1; i++) cycle(1'b0, 1'b0, 3'd0, 8'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 3'(i + 2), 8'(8'hC0 + i));
    In_valid = 1'b1;
    Wr_stall = 1'b0;
    do_reset("rst_run");
    for (int i = 0; i < 3; i++) rand_cycle(30);

    // Reset mid-sweep restarts from r0
    do_reset("rst_sweep");
    for (int i = 0; i < 200; i++) rand_cycle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
